inst_rom: RTL and testbench

INST_ROM -- requirements
Module: inst_rom

---
 rtl/inst_rom_if.sv | 35 +++
 rtl/inst_rom.sv | 83 ++++++++
 tb/tb_inst_rom.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_if.sv
// Fetch and program-load bus for inst_rom.
// parity_err exists only when INST_ROM_PARITY_EN is defined.
interface inst_rom_if;
  logic        ce;
  logic [31:0] addr;
  logic        stall;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] inst;
  logic        inst_valid;
  logic        addr_err;
  logic [31:0] fetch_cnt;
`ifdef INST_ROM_PARITY_EN
  logic        parity_err;

  modport master (
    output ce, addr, stall, ld_we, ld_addr, ld_data,
    input  inst, inst_valid, addr_err, fetch_cnt, parity_err
  );
  modport slave (
    input  ce, addr, stall, ld_we, ld_addr, ld_data,
    output inst, inst_valid, addr_err, fetch_cnt, parity_err
  );
`else
  modport master (
    output ce, addr, stall, ld_we, ld_addr, ld_data,
    input  inst, inst_valid, addr_err, fetch_cnt
  );
  modport slave (
    input  ce, addr, stall, ld_we, ld_addr, ld_data,
    output inst, inst_valid, addr_err, fetch_cnt
  );
`endif
endinterface

// File: rtl/inst_rom.sv
// 1024x32 loadable instruction memory with a one-cycle registered fetch port.
// Define INST_ROM_PARITY_EN to add a per-word even-parity bit and parity_err.
module inst_rom (
  input  logic        clk,
  input  logic        rst,
  inst_rom_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} state_t;

  function automatic logic even_par(input logic [31:0] w);
    return ^w;
  endfunction

  logic [31:0] mem [0:1023];
`ifdef INST_ROM_PARITY_EN
  logic        mem_par [0:1023];
  logic        parity_err_p1;
`endif

  state_t      state_q, state_d;
  logic [9:0]  idx;
  logic        bad_addr;
  logic        accept;
  logic [31:0] inst_p1;
  logic        addr_err_p1;
  logic [31:0] fetch_cnt_p1;

  assign idx      = bus.addr[11:2];
  assign bad_addr = (bus.addr[1:0] != 2'b00) || (bus.addr[31:12] != 20'd0);
  assign accept   = bus.ce && !bus.stall;

  // Load port: storage is never reset; strobes during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst && bus.ld_we) begin
      mem[bus.ld_addr] <= bus.ld_data;
`ifdef INST_ROM_PARITY_EN
      mem_par[bus.ld_addr] <= even_par(bus.ld_data);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.stall) begin
      if (bus.ce) state_d = VALID;
      else        state_d = EMPTY;
    end
  end

  // Fetch stage p1: the nonblocking read sees pre-load contents on a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_p1       <= 32'd0;
      addr_err_p1   <= 1'b0;
      fetch_cnt_p1  <= 32'd0;
`ifdef INST_ROM_PARITY_EN
      parity_err_p1 <= 1'b0;
`endif
    end else if (accept) begin
      inst_p1      <= bad_addr ? 32'd0 : mem[idx];
      addr_err_p1  <= bad_addr;
      fetch_cnt_p1 <= fetch_cnt_p1 + 32'd1;
`ifdef INST_ROM_PARITY_EN
      parity_err_p1 <= bad_addr ? 1'b0 : (even_par(mem[idx]) != mem_par[idx]);
`endif
    end
  end

  assign bus.inst       = inst_p1;
  assign bus.inst_valid = (state_q == VALID);
  assign bus.addr_err   = addr_err_p1;
  assign bus.fetch_cnt  = fetch_cnt_p1;
`ifdef INST_ROM_PARITY_EN
  assign bus.parity_err = parity_err_p1;
`endif

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: stimulus queues expected fetch results,
// a negedge monitor pops one entry each time fetch_cnt advances.
module tb_inst_rom;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_rom_if bus();
  inst_rom dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [31:0] cnt;
    logic        par;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee, input logic ep);
    exp_t e;
    bus.ce = 1'b1;
    bus.addr = a;
    bus.stall = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    e.inst = ei; e.err = ee; e.cnt = exp_cnt; e.par = ep;
    q.push_back(e);
    step();
  endtask

  task automatic load(input logic [9:0] i, input logic [31:0] d);
    bus.ld_we = 1'b1;
    bus.ld_addr = i;
    bus.ld_data = d;
    step();
    bus.ld_we = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_inst"}, bus.inst, 32'd0);
    chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_addr_err"}, 32'(bus.addr_err), 32'd0);
    chk({tag, "_cnt"}, bus.fetch_cnt, 32'd0);
`ifdef INST_ROM_PARITY_EN
    chk({tag, "_parity"}, 32'(bus.parity_err), 32'd0);
`endif
  endtask

  // Monitor: each fetch_cnt change outside reset is one returned fetch.
  initial begin
    logic [31:0] last;
    exp_t e;
    last = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) last = bus.fetch_cnt;
      else if (bus.fetch_cnt !== last) begin
        last = bus.fetch_cnt;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch actual cnt=%h required=no fetch", bus.fetch_cnt);
        end else begin
          e = q.pop_front();
          chk("fetch_inst", bus.inst, e.inst);
          chk("fetch_addr_err", 32'(bus.addr_err), 32'(e.err));
          chk("fetch_valid", 32'(bus.inst_valid), 32'd1);
          chk("fetch_cnt", bus.fetch_cnt, e.cnt);
`ifdef INST_ROM_PARITY_EN
          chk("fetch_parity", 32'(bus.parity_err), 32'(e.par));
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.ce = 1'b0; bus.addr = 32'd0; bus.stall = 1'b0;
    bus.ld_we = 1'b0; bus.ld_addr = 10'd0; bus.ld_data = 32'd0;
    step(); step();
    chk_zero("reset");

    rst = 1'b1;
    load(10'd3, 32'h34011100);
    load(10'd5, 32'hAAAA0000);
    load(10'd7, 32'h11111111);
    load(10'd8, 32'h12345678);
    load(10'd1023, 32'hCAFEF00D);
    chk("idle_valid", 32'(bus.inst_valid), 32'd0);

    fetch(32'h0000000C, 32'h34011100, 1'b0, 1'b0);
    fetch(32'h00000006, 32'h00000000, 1'b1, 1'b0);
    fetch(32'h00001000, 32'h00000000, 1'b1, 1'b0);
    fetch(32'h00000FFC, 32'hCAFEF00D, 1'b0, 1'b0);

    // Stall with ce high and wandering address: everything holds.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ce = 1'b1;
      bus.addr = 32'h00000014 + 32'(i * 4);
      step();
      chk("stall_inst", bus.inst, 32'hCAFEF00D);
      chk("stall_cnt", bus.fetch_cnt, 32'd4);
      chk("stall_valid", 32'(bus.inst_valid), 32'd1);
    end
    fetch(32'h00000020, 32'h12345678, 1'b0, 1'b0);

    bus.ce = 1'b0; bus.stall = 1'b1;
    step();
    chk("stall_noce_valid", 32'(bus.inst_valid), 32'd1);
    bus.stall = 1'b0;
    step();
    chk("idle_empty_valid", 32'(bus.inst_valid), 32'd0);
    chk("idle_hold_inst", bus.inst, 32'h12345678);

    // Read-before-write on a same-word collision.
    bus.ld_we = 1'b1; bus.ld_addr = 10'd5; bus.ld_data = 32'h5555FFFF;
    fetch(32'h00000014, 32'hAAAA0000, 1'b0, 1'b0);
    bus.ld_we = 1'b0;
    fetch(32'h00000014, 32'h5555FFFF, 1'b0, 1'b0);

    // Loads proceed while stalled.
    bus.ce = 1'b0; bus.stall = 1'b1;
    load(10'd9, 32'h0BADF00D);
    fetch(32'h00000024, 32'h0BADF00D, 1'b0, 1'b0);

`ifdef INST_ROM_PARITY_EN
    bus.ce = 1'b0;
    step();
    dut.mem[3] = dut.mem[3] ^ 32'h00000010;
    fetch(32'h0000000C, 32'h34011110, 1'b0, 1'b1);
    fetch(32'h00000020, 32'h12345678, 1'b0, 1'b0);
    fetch(32'h00000005, 32'h00000000, 1'b1, 1'b0);
`endif

    bus.ce = 1'b0;
    step(); step();

    // Mid-cycle async reset with a pending fetch and a load that must be dropped.
    #1;
    rst = 1'b0;
    bus.ce = 1'b1; bus.addr = 32'h0000001C;
    bus.ld_we = 1'b1; bus.ld_addr = 10'd7; bus.ld_data = 32'h22222222;
    #1;
    chk_zero("async_reset");
    step(); step();
    chk_zero("held_reset");
    bus.ld_we = 1'b0;
    rst = 1'b1;
    exp_cnt = 32'd0;
    fetch(32'h0000001C, 32'h11111111, 1'b0, 1'b0);
    fetch(32'h0000000C, 32'h34011100, 1'b0, 1'b0);

    bus.ce = 1'b0;
    step(); step();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
